// File: rtl/axis_video_frame_arbiter.sv
// Two-source AXI4-Stream video arbiter: grants whole frames (tuser-delimited),
// round-robin on contention, drops mid-frame beats while idle and flags stray SOFs.
module axis_video_frame_arbiter #(
    parameter int IMAGE_HEIGHT   = 426,
    parameter int PIXEL_PER_CLK  = 1,
    parameter int BITS_PER_PIXEL = 32,
    localparam int DW = BITS_PER_PIXEL * PIXEL_PER_CLK,
    localparam int LW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    src_enable,

    input  logic [DW-1:0] s0_axis_video_in_tdata,
    input  logic          s0_axis_video_in_tvalid,
    output logic          s0_axis_video_in_tready,
    input  logic          s0_axis_video_in_tlast,
    input  logic          s0_axis_video_in_tuser,

    input  logic [DW-1:0] s1_axis_video_in_tdata,
    input  logic          s1_axis_video_in_tvalid,
    output logic          s1_axis_video_in_tready,
    input  logic          s1_axis_video_in_tlast,
    input  logic          s1_axis_video_in_tuser,

    output logic [DW-1:0] m_axis_video_out_tdata,
    output logic          m_axis_video_out_tvalid,
    input  logic          m_axis_video_out_tready,
    output logic          m_axis_video_out_tlast,
    output logic          m_axis_video_out_tuser,

    output logic          grant_valid,
    output logic          grant_idx,
    output logic [LW-1:0] line_cnt,
    output logic          frame_done,
    output logic          sof_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [LW-1:0] LAST_LINE = LW'(IMAGE_HEIGHT - 1);

    state_t        state, state_nxt;
    logic          grant_idx_nxt;
    logic          rr_ptr, rr_ptr_nxt;
    logic          first_beat, first_beat_nxt;
    logic [LW-1:0] line_cnt_nxt;
    logic          frame_done_nxt, sof_err_nxt;
    logic [1:0]    s_tvalid, s_tlast, s_tuser, cand, ready;
    logic          beat_acc;

    assign s_tvalid = {s1_axis_video_in_tvalid, s0_axis_video_in_tvalid};
    assign s_tlast  = {s1_axis_video_in_tlast,  s0_axis_video_in_tlast};
    assign s_tuser  = {s1_axis_video_in_tuser,  s0_axis_video_in_tuser};
    assign cand     = src_enable & s_tvalid & s_tuser;

    assign s0_axis_video_in_tready = ready[0];
    assign s1_axis_video_in_tready = ready[1];
    assign grant_valid             = (state == ACTIVE);

    always_comb begin
        state_nxt               = state;
        grant_idx_nxt           = grant_idx;
        rr_ptr_nxt              = rr_ptr;
        first_beat_nxt          = first_beat;
        line_cnt_nxt            = line_cnt;
        frame_done_nxt          = 1'b0;
        sof_err_nxt             = 1'b0;
        ready                   = 2'b00;
        beat_acc                = 1'b0;
        m_axis_video_out_tvalid = 1'b0;
        m_axis_video_out_tdata  = grant_idx ? s1_axis_video_in_tdata : s0_axis_video_in_tdata;
        m_axis_video_out_tlast  = s_tlast[grant_idx];
        m_axis_video_out_tuser  = s_tuser[grant_idx];

        case (state)
            IDLE: begin
                // Enabled sources that are mid-frame get drained; SOF beats wait for the grant.
                ready = src_enable & ~s_tuser;
                if (cand != 2'b00) begin
                    state_nxt      = ACTIVE;
                    first_beat_nxt = 1'b1;
                    grant_idx_nxt  = (cand == 2'b11) ? rr_ptr : cand[1];
                end
            end
            ACTIVE: begin
                m_axis_video_out_tvalid = s_tvalid[grant_idx];
                ready[grant_idx]        = m_axis_video_out_tready;
                beat_acc                = m_axis_video_out_tvalid & m_axis_video_out_tready;
                if (beat_acc) begin
                    first_beat_nxt = 1'b0;
                    // A stray SOF restarts the frame in place, even on what would be the final tlast.
                    if (m_axis_video_out_tuser && !first_beat) begin
                        sof_err_nxt  = 1'b1;
                        line_cnt_nxt = '0;
                    end else if (m_axis_video_out_tlast) begin
                        if (line_cnt == LAST_LINE) begin
                            state_nxt      = IDLE;
                            line_cnt_nxt   = '0;
                            frame_done_nxt = 1'b1;
                            rr_ptr_nxt     = ~grant_idx;
                        end else begin
                            line_cnt_nxt = line_cnt + 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (!rst_n) begin
            ready                   = 2'b00;
            m_axis_video_out_tvalid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_idx  <= 1'b0;
            rr_ptr     <= 1'b0;
            first_beat <= 1'b0;
            line_cnt   <= '0;
            frame_done <= 1'b0;
            sof_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_idx  <= grant_idx_nxt;
            rr_ptr     <= rr_ptr_nxt;
            first_beat <= first_beat_nxt;
            line_cnt   <= line_cnt_nxt;
            frame_done <= frame_done_nxt;
            sof_err    <= sof_err_nxt;
        end
    end

endmodule
